// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message front-end: packs a byte-granular word stream into padded 512-bit
// chunks, hands them one at a time to the chunk core and chains the results.
module sha256_msg_ctrl #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  s_data,
    input  logic [2:0]   s_bytes,
    input  logic         s_last,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [511:0] core_chunk,
    output logic [255:0] core_hash,
    output logic         core_vld,
    input  logic [255:0] core_out_hash,
    input  logic         core_out_vld,
    output logic [255:0] digest,
    output logic         digest_vld
);

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT    = 2'd1,
        WAIT    = 2'd2,
        PADX    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [511:0]       buf_q, buf_d;
    logic [3:0]         widx_q, widx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               final_q, final_d;
    logic               extra_q, extra_d;
    logic               pad80_q, pad80_d;
    logic               s_ready_q, s_ready_d;
    logic [511:0]       core_chunk_q, core_chunk_d;
    logic [255:0]       core_hash_q, core_hash_d;
    logic               core_vld_q, core_vld_d;
    logic [255:0]       digest_q, digest_d;
    logic               digest_vld_q, digest_vld_d;

    logic [2:0]         eff_bytes;
    logic [31:0]        s_word;
    logic [511:0]       merged;
    logic [511:0]       last_chunk;
    logic [511:0]       pad_chunk;
    logic [6:0]         n_bytes;
    logic               short_msg;
    logic [LEN_W-1:0]   len_acc;
    logic [63:0]        len_field_acc;
    logic [63:0]        len_field_q;

    // Out-of-range byte counts are treated as a full word.
    assign eff_bytes     = (s_bytes > 3'd4) ? 3'd4 : s_bytes;
    assign n_bytes       = {1'b0, widx_q, 2'b00} + {4'b0000, eff_bytes};
    assign short_msg     = (n_bytes <= 7'd55);
    assign len_acc       = len_q + LEN_W'({eff_bytes, 3'b000});
    assign len_field_acc = 64'(len_acc);
    assign len_field_q   = 64'(len_q);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign s_word[31-8*gi -: 8] = (eff_bytes > 3'(gi)) ? s_data[31-8*gi -: 8] : 8'h00;
        end

        for (gi = 0; gi < 16; gi++) begin : g_word
            assign merged[511-32*gi -: 32] = (widx_q == 4'(gi)) ? s_word : buf_q[511-32*gi -: 32];
        end

        // Bytes past the message are already zero because the buffer is cleared per chunk.
        for (gi = 0; gi < 64; gi++) begin : g_pad
            if (gi < 56) begin : g_body
                assign last_chunk[511-8*gi -: 8] =
                    (n_bytes == 7'(gi)) ? 8'h80 : merged[511-8*gi -: 8];
            end else begin : g_len
                assign last_chunk[511-8*gi -: 8] =
                    short_msg ? len_field_acc[63-8*(gi-56) -: 8] :
                    ((n_bytes == 7'(gi)) ? 8'h80 : merged[511-8*gi -: 8]);
            end
        end
    endgenerate

    assign pad_chunk = {(pad80_q ? 8'h80 : 8'h00), 440'h0, len_field_q};

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        widx_d       = widx_q;
        len_d        = len_q;
        final_d      = final_q;
        extra_d      = extra_q;
        pad80_d      = pad80_q;
        core_chunk_d = core_chunk_q;
        core_hash_d  = core_hash_q;
        core_vld_d   = 1'b0;
        digest_d     = digest_q;
        digest_vld_d = 1'b0;

        case (state_q)
            COLLECT: begin
                if (s_valid && s_ready_q) begin
                    len_d = len_acc;
                    if (s_last) begin
                        core_chunk_d = last_chunk;
                        core_vld_d   = 1'b1;
                        state_d      = EMIT;
                        if (short_msg) begin
                            final_d = 1'b1;
                            extra_d = 1'b0;
                            pad80_d = 1'b0;
                        end else begin
                            final_d = 1'b0;
                            extra_d = 1'b1;
                            pad80_d = (n_bytes == 7'd64);
                        end
                    end else if (widx_q == 4'd15) begin
                        core_chunk_d = merged;
                        core_vld_d   = 1'b1;
                        state_d      = EMIT;
                        final_d      = 1'b0;
                        extra_d      = 1'b0;
                    end else begin
                        buf_d  = merged;
                        widx_d = widx_q + 4'd1;
                    end
                end
            end
            EMIT: begin
                buf_d   = '0;
                widx_d  = 4'd0;
                state_d = WAIT;
            end
            WAIT: begin
                // Results are only meaningful here; elsewhere they are stale.
                if (core_out_vld) begin
                    core_hash_d = core_out_hash;
                    if (extra_q) begin
                        state_d = PADX;
                    end else if (final_q) begin
                        digest_d     = core_out_hash;
                        digest_vld_d = 1'b1;
                        core_hash_d  = IV;
                        len_d        = '0;
                        final_d      = 1'b0;
                        state_d      = COLLECT;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            PADX: begin
                core_chunk_d = pad_chunk;
                core_vld_d   = 1'b1;
                final_d      = 1'b1;
                extra_d      = 1'b0;
                pad80_d      = 1'b0;
                state_d      = EMIT;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        s_ready_d = (state_d == COLLECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            buf_q        <= '0;
            widx_q       <= 4'd0;
            len_q        <= '0;
            final_q      <= 1'b0;
            extra_q      <= 1'b0;
            pad80_q      <= 1'b0;
            s_ready_q    <= 1'b0;
            core_chunk_q <= '0;
            core_hash_q  <= IV;
            core_vld_q   <= 1'b0;
            digest_q     <= '0;
            digest_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            widx_q       <= widx_d;
            len_q        <= len_d;
            final_q      <= final_d;
            extra_q      <= extra_d;
            pad80_q      <= pad80_d;
            s_ready_q    <= s_ready_d;
            core_chunk_q <= core_chunk_d;
            core_hash_q  <= core_hash_d;
            core_vld_q   <= core_vld_d;
            digest_q     <= digest_d;
            digest_vld_q <= digest_vld_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign core_chunk = core_chunk_q;
    assign core_hash  = core_hash_q;
    assign core_vld   = core_vld_q;
    assign digest     = digest_q;
    assign digest_vld = digest_vld_q;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Bench for sha256_msg_ctrl: behavioural SHA-256 core plus a byte-level padding and
// hashing reference; directed known-answer messages followed by random ones.
module tb_sha256_msg_ctrl;

    typedef logic [7:0] bq_t[$];

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  s_data;
    logic [2:0]   s_bytes;
    logic         s_last;
    logic         s_valid;
    logic         s_ready;
    logic [511:0] core_chunk;
    logic [255:0] core_hash;
    logic         core_vld;
    logic [255:0] core_out_hash;
    logic         core_out_vld;
    logic [255:0] digest;
    logic         digest_vld;

    always #5 clk = ~clk;

    sha256_msg_ctrl #(.LEN_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_bytes      (s_bytes),
        .s_last       (s_last),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .core_chunk   (core_chunk),
        .core_hash    (core_hash),
        .core_vld     (core_vld),
        .core_out_hash(core_out_hash),
        .core_out_vld (core_out_vld),
        .digest       (digest),
        .digest_vld   (digest_vld)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic bq_t str_q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Core stand-in with no reset, plus capture of everything the DUT emits.
    logic [511:0] cap_chunk[$];
    logic [255:0] cap_hash[$];
    logic [255:0] dig_q[$];
    int           viol     = 0;
    int           core_lat = 258;

    initial begin : core_model
        int           cyc;
        int           due[$];
        logic [255:0] res[$];
        bit           inflight;
        cyc = 0;
        inflight = 1'b0;
        core_out_vld = 1'b0;
        core_out_hash = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                inflight = 1'b0;
            end else begin
                if (inflight && s_ready) viol++;
                if (core_vld) begin
                    if (inflight) viol++;
                    inflight = 1'b1;
                    cap_chunk.push_back(core_chunk);
                    cap_hash.push_back(core_hash);
                end
                if (digest_vld) dig_q.push_back(digest);
            end
            if (core_vld) begin
                due.push_back(cyc + core_lat);
                res.push_back(sha_compress(core_hash, core_chunk));
            end
            if (due.size() > 0 && due[0] <= cyc) begin
                core_out_vld = 1'b1;
                core_out_hash = res.pop_front();
                void'(due.pop_front());
                inflight = 1'b0;
            end else begin
                core_out_vld = 1'b0;
                core_out_hash = {$urandom(), $urandom(), $urandom(), $urandom(),
                                 $urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
    end

    // Drives one message; called and returns at a falling edge.
    task automatic send_words(input bq_t m, input bit empty_tail, input string tag);
        int L, nw, nb, t;
        logic [31:0] data;
        L = m.size();
        nw = (L + 3) / 4;
        if ((L % 4 == 0) && (empty_tail || L == 0)) nw++;
        for (int w = 0; w < nw; w++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            nb = L - 4 * w;
            if (nb > 4) nb = 4;
            if (nb < 0) nb = 0;
            data = $urandom();
            for (int b = 0; b < nb; b++) data[31-8*b -: 8] = m[4*w+b];
            s_data  = data;
            s_bytes = 3'(nb);
            s_last  = (w == nw - 1);
            s_valid = 1'b1;
            t = 0;
            while (!s_ready && t < core_lat + 100) begin
                @(negedge clk);
                t++;
            end
            if (!s_ready) begin
                check_val({tag, ":s_ready_timeout"}, 0, 1);
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_msg(input bq_t m, input bit empty_tail, input string tag,
                           output logic [255:0] dig, output logic [511:0] first_c,
                           output logic [511:0] last_c);
        bq_t          p;
        logic [511:0] exp_chunks[$];
        logic [511:0] ch;
        logic [255:0] h;
        longint       bits;
        int           budget;
        cap_chunk.delete();
        cap_hash.delete();
        dig_q.delete();
        viol = 0;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = longint'(m.size()) * 8;
        for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
        for (int c = 0; c < p.size() / 64; c++) begin
            for (int b = 0; b < 64; b++) ch[511-8*b -: 8] = p[64*c+b];
            exp_chunks.push_back(ch);
        end
        send_words(m, empty_tail, tag);
        budget = (exp_chunks.size() + 1) * (core_lat + 20) + 200;
        for (int t = 0; t < budget && dig_q.size() == 0; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        check_val({tag, ":n_chunks"}, cap_chunk.size(), exp_chunks.size());
        h = IV;
        for (int i = 0; i < exp_chunks.size(); i++) begin
            if (i < cap_chunk.size()) begin
                check_val($sformatf("%s:chunk%0d", tag, i), cap_chunk[i], exp_chunks[i]);
                check_val($sformatf("%s:in_hash%0d", tag, i), cap_hash[i], h);
            end
            h = sha_compress(h, exp_chunks[i]);
        end
        check_val({tag, ":n_digest"}, dig_q.size(), 1);
        dig = (dig_q.size() > 0) ? dig_q[0] : '0;
        check_val({tag, ":digest"}, dig, h);
        check_val({tag, ":ready_in_wait"}, viol, 0);
        first_c = (cap_chunk.size() > 0) ? cap_chunk[0] : '0;
        last_c  = (cap_chunk.size() > 0) ? cap_chunk[cap_chunk.size()-1] : '0;
        $display("[TB] %s: %0d bytes, %0d chunks, digest %h", tag, m.size(), cap_chunk.size(), dig);
    endtask

    initial begin
        bq_t          m;
        logic [255:0] dig;
        logic [511:0] fc, lc;
        int           L;

        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_bytes = '0;
        s_last = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst:s_ready", s_ready, 0);
        check_val("rst:core_vld", core_vld, 0);
        check_val("rst:core_chunk", core_chunk, 0);
        check_val("rst:core_hash", core_hash, IV);
        check_val("rst:digest", digest, 0);
        check_val("rst:digest_vld", digest_vld, 0);
        rst = 1'b0;
        check_val("rst:s_ready_hold", s_ready, 0);
        @(negedge clk);
        check_val("rst:s_ready_rise", s_ready, 1);

        core_lat = 258;
        run_msg(str_q("abc"), 1'b0, "abc", dig, fc, lc);
        check_val("abc:chunk_kat", fc, {32'h61626380, 448'h0, 32'h00000018});
        check_val("abc:digest_kat", dig,
            256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);

        m.delete();
        run_msg(m, 1'b1, "empty", dig, fc, lc);
        check_val("empty:chunk_kat", fc, {32'h80000000, 480'h0});
        check_val("empty:digest_kat", dig,
            256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);

        run_msg(str_q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 1'b0, "m56",
                dig, fc, lc);
        check_val("m56:len_field", lc[63:0], 64'h1c0);
        check_val("m56:digest_kat", dig,
            256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);

        m.delete();
        for (int i = 0; i < 64; i++) m.push_back(8'($urandom()));
        run_msg(m, 1'b0, "m64", dig, fc, lc);
        check_val("m64:pad_chunk", lc, {32'h80000000, 448'h0, 32'h00000200});

        m.delete();
        for (int i = 0; i < 55; i++) m.push_back(8'($urandom()));
        run_msg(m, 1'b0, "m55", dig, fc, lc);
        check_val("m55:pad80", lc[511-8*55 -: 8], 8'h80);
        check_val("m55:len_field", lc[63:0], 64'h1b8);

        // Reset while the core is busy; its late result must be ignored.
        cap_chunk.delete();
        dig_q.delete();
        send_words(str_q("abc"), 1'b0, "rst_mid");
        for (int t = 0; t < 50 && cap_chunk.size() == 0; t++) @(negedge clk);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid:core_vld", core_vld, 0);
        check_val("rst_mid:s_ready", s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (250) @(negedge clk);
        check_val("rst_mid:no_digest", dig_q.size(), 0);
        check_val("rst_mid:no_core_vld", cap_chunk.size(), 1);
        check_val("rst_mid:core_hash_iv", core_hash, IV);
        check_val("rst_mid:s_ready_up", s_ready, 1);
        run_msg(str_q("abc"), 1'b0, "abc_after_rst", dig, fc, lc);
        check_val("abc_after_rst:digest_kat", dig,
            256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);

        for (int r = 0; r < 25; r++) begin
            core_lat = $urandom_range(4, 40);
            L = $urandom_range(0, 140);
            m.delete();
            for (int i = 0; i < L; i++) m.push_back(8'($urandom()));
            run_msg(m, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r), dig, fc, lc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_msg_ctrl.md
Name: sha256_msg_ctrl

Overview:
- Message front-end for the pipelined `sha256` chunk core; sits directly upstream of it.
- Accepts a byte-granular 32-bit word stream for one message at a time.
- Applies SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length) and packs 512-bit chunks. It issues one chunk at a time to the core and chains each core result as the next chunk's `in_hash`.
- Returns the final 256-bit digest.

Parameters:
- LEN_W, 64, width of the message bit-length counter. Range 16..64. The counter is zero-extended into the 64-bit length field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_data  in  32  message word; first byte in [31:24]
- s_bytes  in  3  valid bytes in s_data: must be 4 when s_last=0; 0..4 allowed when s_last=1
- s_last  in  1  final word of message
- s_valid  in  1  word valid
- s_ready  out  1  word accepted when s_valid & s_ready
- core_chunk  out  512  chunk to core; word 0 in [511:480]
- core_hash  out  256  chaining hash to core; H0 in [255:224]
- core_vld  out  1  one-cycle chunk strobe to core in_vld
- core_out_hash  in  256  core out_hash
- core_out_vld  in  1  core out_vld
- digest  out  256  final hash; H0 in [255:224]
- digest_vld  out  1  one-cycle digest strobe

Behaviour:
- Reset values:
  - s_ready=0, core_vld=0, core_chunk=0, digest=0, digest_vld=0.
  - core_hash=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - Length counter=0, word index=0, state=COLLECT.
  - s_ready rises the cycle after rst deasserts.
- States: COLLECT, EMIT, WAIT, PADX.
- COLLECT:
  - s_ready=1. Each accepted word is stored at word index widx (0..15), and len += 8*s_bytes (mod 2^LEN_W).
  - Bytes beyond s_bytes are forced to 0.
  - Non-last word with widx=15: go to EMIT with buffer as chunk, more_msg=1.
  - Last word: let n = bytes in chunk including this word (0..64).
    - If n<64, 0x80 is placed at byte n.
    - If n<=55: length goes in bytes 56..63, final=1.
    - If 56<=n<=63: final=0, pending extra chunk (zeros + length), pad80_pending=0.
    - If n=64: pending extra chunk with 0x80 at byte 0, pad80_pending=1.
- EMIT:
  - core_vld=1 for exactly one cycle. core_chunk and core_hash are registered and stable that cycle.
  - Emission occurs the cycle after the accepting handshake.
  - Next state is WAIT. The buffer clears to zero, widx=0, s_ready=0.
- WAIT:
  - s_ready=0; waits for core_out_vld. Expected core latency is 258 cycles from core_vld; the block does not count cycles.
  - On core_out_vld: core_hash <= core_out_hash, then select the next state:
    - If an extra pad chunk is pending: go to PADX.
    - Else if final: digest <= core_out_hash; digest_vld=1 the next cycle. Then core_hash <= IV, len=0, and go to COLLECT.
    - Else: go to COLLECT (continue message).
- PADX: builds the extra chunk (0x80 at byte 0 if pad80_pending, zeros, length in bytes 56..63). Sets final=1 and goes to EMIT.
- Ordering: at most one chunk is in flight. core_out_vld is ignored in every state except WAIT; this discards stale results after reset, since the core has no reset.
- A word accepted in the cycle of the digest strobe belongs to the next message.
- rst mid-operation discards buffer, length and chaining state. It produces no digest_vld and no core_vld.
- Length wrap: len modulo 2^LEN_W; the upper (64-LEN_W) bits of the length field are 0.

Test Plan:
1. "abc" = one word 61626300, s_bytes=3, s_last=1 -> one core_vld.
   - Chunk = 61626380, 14 zero words, 00000018.
   - digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
2. Empty message (s_bytes=0, s_last=1) -> chunk 80000000 followed by zeros.
   - digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
3. 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> two core_vld pulses; the second chunk carries length 0x1c0.
   - digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
4. 64-byte message (16 words, last with s_bytes=4) -> two chunks.
   - Second chunk = 80000000, zeros, 00000200.
   - s_ready=0 throughout both WAIT periods.
5. 55-byte message -> single chunk with 0x80 at byte 55 and length 0x1b8. Exactly one digest_vld.
6. Issue "abc" and assert rst 100 cycles into WAIT, then send "abc" again -> the stale core_out_vld arriving in COLLECT is ignored, with no digest_vld from it. Second digest = ba7816bf... (as in scenario 1).
